lc3_mem_arbiter: RTL and testbench

- Shares the single-port main memory between the LC-3 control unit (MIO_EN / R_W / R handshake) and a secondary DMA master (BCI sample buffer writer).
- Sequences every access through a fixed wait-state window.
- Returns R to the microsequencer only when its own access has completed.
- Sits between the CPU datapath's MAR/MDR and the memory macro.

---
 rtl/lc3_mem_arb_pkg.sv | 7 +
 rtl/lc3_mem_arb_pick.sv | 20 ++
 rtl/lc3_mem_arbiter.sv | 81 ++++++++
 tb/tb_lc3_mem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_arb_pkg.sv
// lc3_mem_arb_pkg: shared state encoding, owner ids and wait-counter width for the memory arbiter
package lc3_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/lc3_mem_arb_pick.sv
// lc3_mem_arb_pick: two-input owner selector; round-robin on last_owner, or fixed CPU priority
// when LC3_MEM_ARB_CPU_PRIO_EN is defined.
module lc3_mem_arb_pick
  import lc3_mem_arb_pkg::*;
(
  input  logic cpu_mio_en,
  input  logic dma_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);
  logic tie_owner;
`ifdef LC3_MEM_ARB_CPU_PRIO_EN
  assign tie_owner = OWNER_CPU;
`else
  assign tie_owner = ~last_owner;
`endif
  assign grant_valid = cpu_mio_en | dma_req;
  assign grant_owner = (cpu_mio_en && dma_req) ? tie_owner : (dma_req ? OWNER_DMA : OWNER_CPU);
endmodule

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares single-port memory between the LC-3 CPU and a DMA master
// through a fixed wait-state window (IDLE -> ACCESS -> RESP).
module lc3_mem_arbiter
  import lc3_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_mio_en,
  input  logic              cpu_r_w,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_r,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic last_owner, owner, we, grant_valid, grant_owner;

  lc3_mem_arb_pick u_pick (
    .cpu_mio_en (cpu_mio_en),
    .dma_req    (dma_req),
    .last_owner (last_owner),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  always_comb begin
    state_nx = state == IDLE   ? (grant_valid ? ACCESS : IDLE) :
               state == ACCESS ? (cnt == '0 ? RESP : ACCESS) : IDLE;
    mem_en   = state == ACCESS && cnt == CNT_INIT;
    mem_we   = mem_en && we;
    cpu_r    = state == RESP && owner == OWNER_CPU;
    dma_done = state == RESP && owner == OWNER_DMA;
    dma_gnt  = (state == ACCESS || state == RESP) && owner == OWNER_DMA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= OWNER_DMA;
      owner      <= OWNER_CPU;
      we         <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant_valid) begin
        owner     <= grant_owner;
        we        <= grant_owner == OWNER_DMA ? dma_we : cpu_r_w;
        mem_addr  <= grant_owner == OWNER_DMA ? dma_addr : cpu_addr;
        mem_wdata <= grant_owner == OWNER_DMA ? dma_wdata : cpu_wdata;
        cnt       <= CNT_INIT;
      end
      if (state == ACCESS) begin
        cnt <= cnt == '0 ? '0 : cnt - 1'b1;
        if (cnt == '0) begin
          last_owner <= owner;
          if (!we) rdata <= mem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: directed checks of the arbiter at WAIT_CYCLES = 2 (dut a) and 1 (dut b)
module tb_lc3_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic a_cpu_mio_en = 0, a_cpu_r_w = 0, a_dma_req = 0, a_dma_we = 0;
  logic [15:0] a_cpu_addr = 0, a_cpu_wdata = 0, a_dma_addr = 0, a_dma_wdata = 0;
  logic a_cpu_r, a_dma_gnt, a_dma_done, a_mem_en, a_mem_we;
  logic [15:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic b_cpu_mio_en = 0, b_cpu_r_w = 0, b_dma_req = 0, b_dma_we = 0;
  logic [15:0] b_cpu_addr = 0, b_cpu_wdata = 0, b_dma_addr = 0, b_dma_wdata = 0;
  logic b_cpu_r, b_dma_gnt, b_dma_done, b_mem_en, b_mem_we;
  logic [15:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  // memory model: 16'h3000 holds 16'h1234, every other word reads as ~address
  assign a_mem_rdata = a_mem_addr == 16'h3000 ? 16'h1234 : ~a_mem_addr;
  assign b_mem_rdata = b_mem_addr == 16'h3000 ? 16'h1234 : ~b_mem_addr;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_mio_en(a_cpu_mio_en), .cpu_r_w(a_cpu_r_w), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_r(a_cpu_r),
    .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
    .dma_gnt(a_dma_gnt), .dma_done(a_dma_done), .rdata(a_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_mio_en(b_cpu_mio_en), .cpu_r_w(b_cpu_r_w), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_r(b_cpu_r),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_gnt(b_dma_gnt), .dma_done(b_dma_done), .rdata(b_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {cpu_r, dma_gnt, dma_done, mem_en, mem_we}
  function automatic logic [4:0] a_ctl();
    return {a_cpu_r, a_dma_gnt, a_dma_done, a_mem_en, a_mem_we};
  endfunction
  function automatic logic [4:0] b_ctl();
    return {b_cpu_r, b_dma_gnt, b_dma_done, b_mem_en, b_mem_we};
  endfunction

  initial begin
    logic exp_dma;
    tick();
    tick();
    chk("reset_ctl", {27'd0, a_ctl()}, 32'd0);
    chk("reset_data", {a_rdata, a_mem_addr}, 32'd0);
    chk("reset_wdata", {16'd0, a_mem_wdata}, 32'd0);
    rst = 0;
    tick();

    // CPU read of 16'h3000
    a_cpu_mio_en = 1; a_cpu_r_w = 0; a_cpu_addr = 16'h3000;
    tick();
    chk("rd_t1_ctl", {27'd0, a_ctl()}, 32'b00010);
    chk("rd_t1_addr", {16'd0, a_mem_addr}, 32'h3000);
    tick();
    chk("rd_t2_ctl", {27'd0, a_ctl()}, 32'b00000);
    tick();
    chk("rd_t3_ctl", {27'd0, a_ctl()}, 32'b10000);
    chk("rd_t3_rdata", {16'd0, a_rdata}, 32'h1234);
    a_cpu_mio_en = 0;
    tick();
    chk("rd_t4_ctl", {27'd0, a_ctl()}, 32'b00000);
    tick();
    chk("rd_idle_ctl", {27'd0, a_ctl()}, 32'b00000);

    // DMA write FE00 <= BEEF
    a_dma_req = 1; a_dma_we = 1; a_dma_addr = 16'hFE00; a_dma_wdata = 16'hBEEF;
    tick();
    chk("wr_t1_ctl", {27'd0, a_ctl()}, 32'b01011);
    chk("wr_t1_bus", {a_mem_addr, a_mem_wdata}, 32'hFE00BEEF);
    tick();
    chk("wr_t2_ctl", {27'd0, a_ctl()}, 32'b01000);
    chk("wr_t2_bus", {a_mem_addr, a_mem_wdata}, 32'hFE00BEEF);
    tick();
    chk("wr_t3_ctl", {27'd0, a_ctl()}, 32'b01100);
    chk("wr_t3_bus", {a_mem_addr, a_mem_wdata}, 32'hFE00BEEF);
    chk("wr_rdata_hold", {16'd0, a_rdata}, 32'h1234);
    a_dma_req = 0; a_dma_we = 0;
    tick();
    chk("wr_t4_ctl", {27'd0, a_ctl()}, 32'b00000);

    // DMA read withdrawn one cycle after grant
    a_dma_req = 1; a_dma_addr = 16'h0010;
    tick();
    chk("wd_t1_ctl", {27'd0, a_ctl()}, 32'b01010);
    a_dma_req = 0;
    tick();
    chk("wd_t2_ctl", {27'd0, a_ctl()}, 32'b01000);
    tick();
    chk("wd_t3_ctl", {27'd0, a_ctl()}, 32'b01100);
    chk("wd_rdata", {16'd0, a_rdata}, 32'h0000FFEF);
    tick();
    chk("wd_t4_ctl", {27'd0, a_ctl()}, 32'b00000);
    tick();
    chk("wd_t5_ctl", {27'd0, a_ctl()}, 32'b00000);

    // CPU read completes so last_owner = CPU, then a CPU read is reset mid-access
    a_cpu_mio_en = 1; a_cpu_addr = 16'h0020;
    tick(); tick(); tick();
    chk("pre_rst_cpu_r", {31'd0, a_cpu_r}, 32'd1);
    chk("pre_rst_rdata", {16'd0, a_rdata}, 32'h0000FFDF);
    a_cpu_addr = 16'h0030;
    tick();
    tick();
    chk("ra_access", {27'd0, a_ctl()}, 32'b00010);
    rst = 1;
    tick();
    a_cpu_mio_en = 0;
    chk("ra_ctl", {27'd0, a_ctl()}, 32'd0);
    chk("ra_data", {a_rdata, a_mem_addr}, 32'd0);
    chk("ra_wdata", {16'd0, a_mem_wdata}, 32'd0);
    rst = 0;
    tick();
    chk("ra_no_r1", {27'd0, a_ctl()}, 32'd0);
    tick();
    chk("ra_no_r2", {27'd0, a_ctl()}, 32'd0);

    // simultaneous held requests; first tie after reset goes to the CPU
    a_cpu_mio_en = 1; a_cpu_r_w = 0; a_cpu_addr = 16'h0100;
    a_dma_req = 1; a_dma_we = 0; a_dma_addr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
`ifdef LC3_MEM_ARB_CPU_PRIO_EN
      exp_dma = 1'b0;
`else
      exp_dma = i[0];
`endif
      tick();
      chk($sformatf("tie%0d_t1_ctl", i), {27'd0, a_ctl()}, {27'd0, 1'b0, exp_dma, 1'b0, 2'b10});
      chk($sformatf("tie%0d_addr", i), {16'd0, a_mem_addr}, exp_dma ? 32'h0200 : 32'h0100);
      tick();
      tick();
      chk($sformatf("tie%0d_resp", i), {27'd0, a_ctl()}, {27'd0, ~exp_dma, exp_dma, exp_dma, 2'b00});
      chk($sformatf("tie%0d_rdata", i), {16'd0, a_rdata}, exp_dma ? 32'h0000FDFF : 32'h0000FEFF);
      tick();
      chk($sformatf("tie%0d_idle", i), {27'd0, a_ctl()}, 32'd0);
    end
    a_cpu_mio_en = 0; a_dma_req = 0;
    tick();

    // WAIT_CYCLES = 1: CPU write then immediate CPU read
    b_cpu_mio_en = 1; b_cpu_r_w = 1; b_cpu_addr = 16'h4000; b_cpu_wdata = 16'hCAFE;
    tick();
    chk("w1_wr_t1_ctl", {27'd0, b_ctl()}, 32'b00011);
    chk("w1_wr_t1_bus", {b_mem_addr, b_mem_wdata}, 32'h4000CAFE);
    tick();
    chk("w1_wr_t2_ctl", {27'd0, b_ctl()}, 32'b10000);
    chk("w1_wr_rdata", {16'd0, b_rdata}, 32'd0);
    b_cpu_r_w = 0; b_cpu_addr = 16'h4001;
    tick();
    chk("w1_gap_ctl", {27'd0, b_ctl()}, 32'b00000);
    tick();
    chk("w1_rd_t1_ctl", {27'd0, b_ctl()}, 32'b00010);
    chk("w1_rd_t1_addr", {16'd0, b_mem_addr}, 32'h4001);
    tick();
    chk("w1_rd_t2_ctl", {27'd0, b_ctl()}, 32'b10000);
    chk("w1_rd_rdata", {16'd0, b_rdata}, 32'h0000BFFE);
    b_cpu_mio_en = 0;
    tick();
    chk("w1_end_ctl", {27'd0, b_ctl()}, 32'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
